operand_collector: RTL

- Sits directly upstream of one register_file_bank: drives the bank's read request port and consumes its registered read response.
- Accepts one instruction carrying up to NumOperands source register addresses.
- Issues one bank read per needed operand, gathers the returned data, then presents the complete operand set to the execute stage over a valid/ready handshake.

---
 rtl/operand_collector_pkg.sv | 27 ++
 rtl/operand_collector_slot_picker.sv | 30 +++
 rtl/operand_collector.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/operand_collector_pkg.sv
// -----------------------------------------------------------------------------
// operand_collector_pkg
// Shared types for the operand collector: default sizing, data/address/tag
// typedefs, the slot-index type and the collector FSM state encoding.
// -----------------------------------------------------------------------------
package operand_collector_pkg;

  localparam int NUM_OPERANDS   = 3;
  localparam int NUM_REGISTERS  = 256;
  localparam int ADDR_WIDTH     = $clog2(NUM_REGISTERS);
  localparam int DATA_WIDTH     = 32;
  localparam int TAG_WIDTH      = 4;
  localparam int SLOT_IDX_WIDTH = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;

  typedef logic [ADDR_WIDTH-1:0]     addr_t;
  typedef logic [DATA_WIDTH-1:0]     data_t;
  typedef logic [TAG_WIDTH-1:0]      tag_t;
  typedef logic [SLOT_IDX_WIDTH-1:0] slot_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQUEST  = 2'd1,
    ST_WAIT     = 2'd2,
    ST_DISPATCH = 2'd3
  } state_t;

endpackage

// File: rtl/operand_collector_slot_picker.sv
// -----------------------------------------------------------------------------
// operand_slot_picker
// Combinational lowest-set-bit priority encoder over the pending-slot mask.
// Ports:
//   i_pending  N-bit mask of slots still to be requested
//   o_idx      index of the lowest set bit (0 when none set)
//   o_any      at least one bit of i_pending is set
// -----------------------------------------------------------------------------
module operand_slot_picker #(
  parameter int N    = 3,
  parameter int IdxW = 2
) (
  input  logic [N-1:0]    i_pending,
  output logic [IdxW-1:0] o_idx,
  output logic            o_any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_pending[i]) begin
        o_idx = IdxW'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/operand_collector.sv
// -----------------------------------------------------------------------------
// operand_collector
// Accepts one instruction with up to NumOperands source addresses, reads each
// needed operand from a register_file_bank (one request at a time, fixed
// one-cycle response latency), then presents tag + operand set for dispatch.
//
// Handshakes: every valid/ready pair transfers on a rising clock edge where
// both are high; a valid source holds its payload stable until that edge.
// The bank response channel has no ready and is always consumed.
//
// Ports:
//   clk_i, rst_i                   clock, async active-high reset
//   instr_*                        instruction input channel (valid/ready)
//   bank_req_*                     bank read request channel (valid/ready)
//   bank_rsp_*                     bank read response (valid only)
//   disp_*                         operand set to execute stage (valid/ready)
//   dbg_state_o                    current FSM state
//
// Build option: OPERAND_COLLECTOR_BACK_TO_BACK_EN lets a new instruction be
// accepted in the same cycle the previous one dispatches.
// -----------------------------------------------------------------------------
module operand_collector
  import operand_collector_pkg::*;
#(
  parameter int  NumOperands  = NUM_OPERANDS,
  parameter int  NumRegisters = NUM_REGISTERS,
  parameter int  DataWidth    = DATA_WIDTH,
  parameter int  TagWidth     = TAG_WIDTH,
  localparam int AddrWidth    = $clog2(NumRegisters),
  localparam int IdxWidth     = (NumOperands > 1) ? $clog2(NumOperands) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             instr_valid_i,
  output logic                             instr_ready_o,
  input  logic [TagWidth-1:0]              instr_tag_i,
  input  logic [NumOperands-1:0]           instr_op_needed_i,
  input  logic [NumOperands*AddrWidth-1:0] instr_op_addr_i,
  output logic                             bank_req_valid_o,
  input  logic                             bank_req_ready_i,
  output logic [AddrWidth-1:0]             bank_req_addr_o,
  input  logic                             bank_rsp_valid_i,
  input  logic [AddrWidth-1:0]             bank_rsp_addr_i,
  input  logic [DataWidth-1:0]             bank_rsp_data_i,
  output logic                             disp_valid_o,
  input  logic                             disp_ready_i,
  output logic [TagWidth-1:0]              disp_tag_o,
  output logic [NumOperands*DataWidth-1:0] disp_operands_o,
  output state_t                           dbg_state_o
);

  state_t                                r_state;
  logic [TagWidth-1:0]                   r_tag;
  logic [NumOperands-1:0]                r_needed;
  logic [NumOperands-1:0]                r_requested;
  logic [NumOperands-1:0]                r_received;
  logic [NumOperands-1:0][AddrWidth-1:0] r_addr;
  logic [NumOperands-1:0][DataWidth-1:0] r_ops;
  logic                                  r_inflight_valid;
  logic [IdxWidth-1:0]                   r_inflight_idx;
  logic                                  r_instr_ready;

  logic [NumOperands-1:0] w_pending;
  logic [NumOperands-1:0] w_pick_mask;
  logic [NumOperands-1:0] w_rsp_mask;
  logic [IdxWidth-1:0]    w_pick_idx;
  logic                   w_pick_any;
  logic                   w_req_fire;
  logic                   w_rsp_fire;
  logic                   w_last_req;
  logic                   w_disp_fire;
  logic                   w_accept;

  assign w_pending = r_needed & ~r_requested;

  operand_slot_picker #(
    .N    (NumOperands),
    .IdxW (IdxWidth)
  ) u_picker (
    .i_pending (w_pending),
    .o_idx     (w_pick_idx),
    .o_any     (w_pick_any)
  );

  assign w_pick_mask = NumOperands'(1) << w_pick_idx;
  // The slot being requested now is the last one if nothing else is pending.
  assign w_last_req  = (w_pending & ~w_pick_mask) == '0;

  // Responses are only honoured for a request this instance issued; this is
  // what drops a response that was in flight across a reset.
  assign w_rsp_fire = bank_rsp_valid_i && r_inflight_valid;
  assign w_rsp_mask = w_rsp_fire ? (NumOperands'(1) << r_inflight_idx) : '0;

  assign bank_req_valid_o = (r_state == ST_REQUEST) && w_pick_any;
  // Pending mask only changes on a handshake, so the address is stable
  // while the bank stalls.
  assign bank_req_addr_o  = bank_req_valid_o ? r_addr[w_pick_idx] : '0;
  assign w_req_fire       = bank_req_valid_o && bank_req_ready_i;

  assign disp_valid_o    = (r_state == ST_DISPATCH);
  assign disp_tag_o      = r_tag;
  assign disp_operands_o = r_ops;
  assign w_disp_fire     = disp_valid_o && disp_ready_i;
  assign dbg_state_o     = r_state;

`ifdef OPERAND_COLLECTOR_BACK_TO_BACK_EN
  assign instr_ready_o = r_instr_ready || w_disp_fire;
`else
  assign instr_ready_o = r_instr_ready;
`endif

  assign w_accept = instr_valid_i && instr_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state          <= ST_IDLE;
      r_tag            <= '0;
      r_needed         <= '0;
      r_requested      <= '0;
      r_received       <= '0;
      r_addr           <= '0;
      r_ops            <= '0;
      r_inflight_valid <= 1'b0;
      r_inflight_idx   <= '0;
      r_instr_ready    <= 1'b0;
    end else begin
      // Capture first; a request handshake below may re-arm in-flight.
      if (w_rsp_fire) begin
        r_ops[r_inflight_idx] <= bank_rsp_data_i;
        r_received            <= r_received | w_rsp_mask;
        r_inflight_valid      <= 1'b0;
      end

      unique case (r_state)
        ST_IDLE: r_instr_ready <= 1'b1;
        ST_REQUEST: begin
          if (w_req_fire) begin
            r_requested      <= r_requested | w_pick_mask;
            r_inflight_idx   <= w_pick_idx;
            r_inflight_valid <= 1'b1;
            if (w_last_req) r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if ((r_received | w_rsp_mask) == r_needed) r_state <= ST_DISPATCH;
        end
        ST_DISPATCH: begin
          if (w_disp_fire) begin
            r_state       <= ST_IDLE;
            r_instr_ready <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Acceptance overrides the state update (back-to-back from DISPATCH).
      if (w_accept) begin
        r_tag         <= instr_tag_i;
        r_needed      <= instr_op_needed_i;
        r_addr        <= instr_op_addr_i;
        r_ops         <= '0;
        r_requested   <= '0;
        r_received    <= '0;
        r_instr_ready <= 1'b0;
        r_state       <= (|instr_op_needed_i) ? ST_REQUEST : ST_DISPATCH;
      end
    end
  end

`ifndef SYNTHESIS
  // Protocol checks against the bank; suppressed during and just after reset.
  logic                 r_chk_en;
  logic                 r_stalled;
  logic [AddrWidth-1:0] r_stall_addr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_chk_en     <= 1'b0;
      r_stalled    <= 1'b0;
      r_stall_addr <= '0;
    end else begin
      r_chk_en     <= 1'b1;
      r_stalled    <= bank_req_valid_o && !bank_req_ready_i;
      r_stall_addr <= bank_req_addr_o;
    end
  end

  always @(posedge clk_i) begin
    if (!rst_i && r_chk_en) begin
      assert (!bank_rsp_valid_i || r_inflight_valid)
        else $error("operand_collector: bank response with no request in flight");
      assert (!w_rsp_fire || (bank_rsp_addr_i == r_addr[r_inflight_idx]))
        else $error("operand_collector: bank response address differs from request");
      assert (!(r_stalled && bank_req_valid_o) || (bank_req_addr_o == r_stall_addr))
        else $error("operand_collector: request address changed while stalled");
    end
  end
`endif

endmodule
